exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage. Sits between ID2EXE and the EXE/MEM pipe register.
- Applies forwarding to the operands and evaluates single-cycle ALU ops combinationally.
- Adds an iterative 32-cycle shift-add multiplier (EXE_CMD MUL) that stalls the front of the pipe until the product is ready.
- Control bits (MEM_R_EN, MEM_W_EN, WB_EN, dest) bypass this block; the stall output tells the hazard unit to gate them.

Parameters:
- WIDTH, 32, datapath width.
- MUL_CYCLES, 32, BUSY iterations; must equal WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- EXE_CMD  in  4  operation from ID2EXE.
- val1  in  32  operand 1 from ID2EXE.
- val2  in  32  operand 2 (register or immediate) from ID2EXE.
- ST_value  in  32  store data from ID2EXE.
- sel_src1  in  2  forward select for val1: 00 pipe, 01 MEM, 10 WB, 11 pipe.
- sel_src2  in  2  forward select for val2, same encoding.
- sel_st  in  2  forward select for ST_value, same encoding.
- mem_fwd_val  in  32  ALU result held in EXE/MEM.
- wb_fwd_val  in  32  writeback value.
- alu_result  out  32  result to EXE/MEM.
- st_value_out  out  32  forwarded store data.
- stall  out  1  hold PC/IF2ID/ID2EXE; load a bubble into EXE/MEM.
- mul_busy  out  1  multiplier FSM not IDLE (debug/perf).

Behaviour:
- Forwarding: op1/op2/st = mux(sel, pipe input, mem_fwd_val, wb_fwd_val). st_value_out = forwarded st.
- Single-cycle ops, combinational on op1/op2, shift amount op2[4:0]:
  - ADD 0000 = sum mod 2^32; SUB 0010 = difference mod 2^32. No overflow trap.
  - SLT 0011 = signed op1<op2 → 1, else 0.
  - AND 0100, OR 0101, NOR 0110, XOR 0111.
  - SLL 1000, SRA 1001, SRL 1010.
  - NOP 1111 and any undefined code → 0.
- MUL 1100: low 32 bits of op1*op2. Signed and unsigned are identical; unsigned shift-add is used.
- Multiplier FSM states: IDLE, BUSY, DONE. 5-bit counter, 64-bit product/accumulator regs.
  - IDLE & EXE_CMD==MUL: latch forwarded op1/op2, clear accumulator and counter → BUSY. Operands are latched because MEM/WB drain while stalled.
  - BUSY: one shift-add iteration per cycle. When counter==MUL_CYCLES-1 → DONE.
  - DONE: alu_result = accumulator[31:0]; → IDLE unconditionally.
- stall = !rst & ((IDLE & EXE_CMD==MUL) | BUSY). DONE has stall=0, so ID2EXE advances and EXE/MEM captures the real result.
- Timing: MUL present at cycle T gives stall high T..T+32 (33 cycles) and the result on alu_result at T+33.
- In IDLE and BUSY with cmd MUL, alu_result = 0. It is don't-care since EXE/MEM takes a bubble.
- Back-to-back MUL: DONE always returns to IDLE. A following MUL (new ID2EXE contents at T+34) restarts the FSM and never re-triggers on the finished one.
- mul_busy = state != IDLE.
- Reset: rst high at any edge forces IDLE, counter 0, accumulator and operand latches 0. This includes mid-BUSY abort; no result is produced.
  - While rst is high: stall=0, mul_busy=0, alu_result/st_value_out follow the combinational paths.
- Operand values 0 or all-ones are not special-cased; all 32 iterations always run.

Decomposition:
- defines.v holds the EXE_CMD codes above (EXE_ADD … EXE_MUL, EXE_NOP) and the forward-select codes (FWD_PIPE, FWD_MEM, FWD_WB).
- Sub-module iter_multiplier owns the FSM, counter and accumulator.
  - Ports: clk, rst, start, a, b → busy, done, product.
- ALU and forwarding muxes stay in exe_stage.

Test Plan:
- ALU ops, sel=00: ADD 0x7FFFFFFF+1 → 0x80000000; SUB 0−1 → 0xFFFFFFFF; SLT −1<1 → 1; SRA 0x80000000 by 4 → 0xF8000000; undefined 1101 → 0; stall=0 throughout.
- Forwarding: val1=5, mem_fwd_val=9, sel_src1=01, val2=1, ADD → 10; sel_st=10, wb_fwd_val=0xAB → st_value_out=0xAB.
- MUL: 7×6, issued cycle 0 → stall high cycles 0–32, alu_result=42 at cycle 33 with stall=0; mul_busy low at cycle 34. Also 0xFFFFFFFF×2 → 0xFFFFFFFE.
- Operand latch: MUL 3×4 via sel_src1=01 with mem_fwd_val=3 at issue; mem_fwd_val changes to 100 at cycle 2 → result still 12.
- Back-to-back MUL 2×3 then 5×5 → results 6 at cycle 33 and 25 at cycle 67. stall is low only on cycle 33 between them.
- Reset mid-operation: rst at cycle 10 of a MUL → next cycle IDLE, stall=0, mul_busy=0. A new MUL issued after rst completes normally in 33 cycles.

Source files
------------

// File: rtl/exe_stage_pkg.sv
// rtl/exe_stage_pkg.sv - execute-stage command, forward-select and multiplier state codes
package exe_stage_pkg;

    typedef enum logic [3:0] {
        EXE_ADD = 4'b0000,
        EXE_SUB = 4'b0010,
        EXE_SLT = 4'b0011,
        EXE_AND = 4'b0100,
        EXE_OR  = 4'b0101,
        EXE_NOR = 4'b0110,
        EXE_XOR = 4'b0111,
        EXE_SLL = 4'b1000,
        EXE_SRA = 4'b1001,
        EXE_SRL = 4'b1010,
        EXE_MUL = 4'b1100,
        EXE_NOP = 4'b1111
    } exe_cmd_e;

    // Code 2'b11 is unused by the hazard unit and falls back to the pipe value.
    typedef enum logic [1:0] {
        FWD_PIPE = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_e;

endpackage

// File: rtl/iter_multiplier.sv
// rtl/iter_multiplier.sv - iterative shift-add multiplier, one partial product per cycle
module iter_multiplier
    import exe_stage_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    mul_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH:0]     hi_sum;
    logic [2*WIDTH-1:0] acc_d;

    // Right-shifting accumulator: low half starts as the multiplier, its LSB
    // selects whether the multiplicand is added into the high half.
    always_comb begin
        hi_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        if (acc_q[0]) begin
            hi_sum = hi_sum + {1'b0, mcand_q};
        end
        acc_d = {hi_sum, acc_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MUL_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
        end else begin
            case (state_q)
                MUL_IDLE: begin
                    if (start) begin
                        mcand_q <= a;
                        acc_q   <= {{WIDTH{1'b0}}, b};
                        cnt_q   <= '0;
                        state_q <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    state_q <= MUL_IDLE;
                end
                default: begin
                    state_q <= MUL_IDLE;
                end
            endcase
        end
    end

    assign busy    = (state_q != MUL_IDLE);
    assign done    = (state_q == MUL_DONE);
    assign product = acc_q[WIDTH-1:0];

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: operand forwarding, single-cycle ALU and stalling multiplier
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       EXE_CMD,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic [WIDTH-1:0] ST_value,
    input  logic [1:0]       sel_src1,
    input  logic [1:0]       sel_src2,
    input  logic [1:0]       sel_st,
    input  logic [WIDTH-1:0] mem_fwd_val,
    input  logic [WIDTH-1:0] wb_fwd_val,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] st_value_out,
    output logic             stall,
    output logic             mul_busy
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [WIDTH-1:0] alu_comb;
    logic [WIDTH-1:0] mul_product;
    logic             is_mul;
    logic             mul_start;
    logic             mul_active;
    logic             mul_done;

    function automatic logic [WIDTH-1:0] fwd_pick(
        input logic [1:0]       sel,
        input logic [WIDTH-1:0] pipe_v,
        input logic [WIDTH-1:0] mem_v,
        input logic [WIDTH-1:0] wb_v
    );
        case (sel)
            FWD_MEM: return mem_v;
            FWD_WB:  return wb_v;
            default: return pipe_v;
        endcase
    endfunction

    assign op1          = fwd_pick(sel_src1, val1, mem_fwd_val, wb_fwd_val);
    assign op2          = fwd_pick(sel_src2, val2, mem_fwd_val, wb_fwd_val);
    assign st_value_out = fwd_pick(sel_st, ST_value, mem_fwd_val, wb_fwd_val);

    always_comb begin
        alu_comb = '0;
        case (EXE_CMD)
            EXE_ADD: alu_comb = op1 + op2;
            EXE_SUB: alu_comb = op1 - op2;
            EXE_SLT: alu_comb = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            EXE_AND: alu_comb = op1 & op2;
            EXE_OR:  alu_comb = op1 | op2;
            EXE_NOR: alu_comb = ~(op1 | op2);
            EXE_XOR: alu_comb = op1 ^ op2;
            EXE_SLL: alu_comb = op1 << op2[SHW-1:0];
            EXE_SRA: alu_comb = $signed(op1) >>> op2[SHW-1:0];
            EXE_SRL: alu_comb = op1 >> op2[SHW-1:0];
            default: alu_comb = '0;
        endcase
    end

    // The multiplier only sees a start while IDLE, so the MUL still sitting in
    // ID2EXE during DONE cannot retrigger it.
    assign is_mul    = (EXE_CMD == EXE_MUL);
    assign mul_start = is_mul && !mul_active && !rst;

    iter_multiplier #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (op1),
        .b       (op2),
        .busy    (mul_active),
        .done    (mul_done),
        .product (mul_product)
    );

    assign stall    = !rst && ((is_mul && !mul_active) || (mul_active && !mul_done));
    assign mul_busy = !rst && mul_active;

    always_comb begin
        alu_result = alu_comb;
        if (mul_done && !rst) begin
            alu_result = mul_product;
        end else if (is_mul) begin
            alu_result = '0;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - self-checking bench for exe_stage against a behavioural model
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  EXE_CMD;
    logic [31:0] val1, val2, ST_value, mem_fwd_val, wb_fwd_val;
    logic [1:0]  sel_src1, sel_src2, sel_st;
    logic [31:0] alu_result, st_value_out;
    logic        stall, mul_busy;

    int checks   = 0;
    int failures = 0;

    exe_stage dut (
        .clk          (clk),
        .rst          (rst),
        .EXE_CMD      (EXE_CMD),
        .val1         (val1),
        .val2         (val2),
        .ST_value     (ST_value),
        .sel_src1     (sel_src1),
        .sel_src2     (sel_src2),
        .sel_st       (sel_st),
        .mem_fwd_val  (mem_fwd_val),
        .wb_fwd_val   (wb_fwd_val),
        .alu_result   (alu_result),
        .st_value_out (st_value_out),
        .stall        (stall),
        .mul_busy     (mul_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] p,
                                          input logic [31:0] m, input logic [31:0] w);
        if (sel == 2'd1) return m;
        if (sel == 2'd2) return w;
        return p;
    endfunction

    function automatic logic [31:0] m_alu(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b);
        int unsigned sh;
        longint sa, sb;
        sh = b % 32;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (cmd)
            4'd0:    return a + b;
            4'd2:    return a - b;
            4'd3:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return ~(a | b);
            4'd7:    return a ^ b;
            4'd8:    return 32'(longint'(a) * (longint'(1) << sh));
            4'd9:    return 32'(sa / (longint'(1) << sh) - ((sa < 0 && (sa % (longint'(1) << sh)) != 0) ? 1 : 0));
            4'd10:   return 32'(longint'(a) / (longint'(1) << sh));
            default: return 32'd0;
        endcase
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic dir_alu(input string tag, input logic [3:0] cmd, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        next_cycle();
        EXE_CMD = cmd; val1 = a; val2 = b;
        sel_src1 = 2'd0; sel_src2 = 2'd0; sel_st = 2'd0;
        @(negedge clk);
        chk(tag, alu_result, exp);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    endtask

    task automatic rand_alu();
        logic [3:0] cmd;
        logic [31:0] o1, o2, os;
        cmd = 4'($urandom_range(0, 15));
        if (cmd == 4'd12) cmd = 4'd15;
        next_cycle();
        EXE_CMD = cmd;
        val1 = rand_word(); val2 = rand_word(); ST_value = $urandom;
        mem_fwd_val = rand_word(); wb_fwd_val = rand_word();
        sel_src1 = 2'($urandom_range(0, 3));
        sel_src2 = 2'($urandom_range(0, 3));
        sel_st   = 2'($urandom_range(0, 3));
        o1 = m_fwd(sel_src1, val1, mem_fwd_val, wb_fwd_val);
        o2 = m_fwd(sel_src2, val2, mem_fwd_val, wb_fwd_val);
        os = m_fwd(sel_st, ST_value, mem_fwd_val, wb_fwd_val);
        @(negedge clk);
        chk($sformatf("alu_cmd%0d", cmd), alu_result, m_alu(cmd, o1, o2));
        chk("st_fwd", st_value_out, os);
        chk("alu_stall", {31'd0, stall}, 32'd0);
        chk("alu_busy", {31'd0, mul_busy}, 32'd0);
    endtask

    // Issues a MUL and holds ID2EXE for 34 cycles (issue, 32 busy, done).
    // MEM/WB forward values keep changing to prove the operands were latched.
    task automatic run_mul(input logic [31:0] v1, input logic [31:0] v2,
                           input logic [1:0] s1, input logic [1:0] s2,
                           input logic [31:0] mem_v, input logic [31:0] wb_v);
        logic [31:0] exp;
        next_cycle();
        EXE_CMD = 4'b1100; val1 = v1; val2 = v2;
        sel_src1 = s1; sel_src2 = s2; sel_st = 2'd0;
        mem_fwd_val = mem_v; wb_fwd_val = wb_v;
        exp = m_fwd(s1, v1, mem_v, wb_v) * m_fwd(s2, v2, mem_v, wb_v);
        @(negedge clk);
        chk("mul_issue_stall", {31'd0, stall}, 32'd1);
        chk("mul_issue_busy", {31'd0, mul_busy}, 32'd0);
        chk("mul_issue_res", alu_result, 32'd0);
        for (int c = 1; c <= 32; c++) begin
            next_cycle();
            mem_fwd_val = (c == 2) ? 32'd100 : $urandom;
            wb_fwd_val  = $urandom;
            @(negedge clk);
            chk($sformatf("mul_stall_c%0d", c), {31'd0, stall}, 32'd1);
            chk($sformatf("mul_busy_c%0d", c), {31'd0, mul_busy}, 32'd1);
        end
        next_cycle();
        @(negedge clk);
        chk("mul_done_stall", {31'd0, stall}, 32'd0);
        chk("mul_done_busy", {31'd0, mul_busy}, 32'd1);
        chk("mul_result", alu_result, exp);
    endtask

    task automatic idle_nop();
        next_cycle();
        EXE_CMD = 4'b1111; sel_src1 = 2'd0; sel_src2 = 2'd0; sel_st = 2'd0;
        @(negedge clk);
        chk("idle_busy", {31'd0, mul_busy}, 32'd0);
        chk("idle_stall", {31'd0, stall}, 32'd0);
        chk("idle_res", alu_result, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        EXE_CMD = 4'b0000; val1 = 32'd2; val2 = 32'd3; ST_value = 32'h55;
        sel_src1 = 2'd0; sel_src2 = 2'd0; sel_st = 2'd0;
        mem_fwd_val = 32'd0; wb_fwd_val = 32'd0;
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_busy", {31'd0, mul_busy}, 32'd0);
        chk("rst_alu", alu_result, 32'd5);
        chk("rst_st", st_value_out, 32'h55);
        next_cycle();
        EXE_CMD = 4'b1100;
        @(negedge clk);
        chk("rst_mul_stall", {31'd0, stall}, 32'd0);
        next_cycle();
        rst = 1'b0;
        EXE_CMD = 4'b1111;

        dir_alu("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
        dir_alu("sub_wrap", 4'b0010, 32'd0, 32'd1, 32'hFFFF_FFFF);
        dir_alu("slt_neg", 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd1);
        dir_alu("slt_pos", 4'b0011, 32'd1, 32'hFFFF_FFFF, 32'd0);
        dir_alu("sra", 4'b1001, 32'h8000_0000, 32'd4, 32'hF800_0000);
        dir_alu("srl", 4'b1010, 32'h8000_0000, 32'd4, 32'h0800_0000);
        dir_alu("sll_mask", 4'b1000, 32'd1, 32'd33, 32'd2);
        dir_alu("undef", 4'b1101, 32'd7, 32'd9, 32'd0);

        next_cycle();
        EXE_CMD = 4'b0000; val1 = 32'd5; val2 = 32'd1; mem_fwd_val = 32'd9;
        sel_src1 = 2'd1; sel_src2 = 2'd0; sel_st = 2'd2; wb_fwd_val = 32'hAB;
        @(negedge clk);
        chk("fwd_add", alu_result, 32'd10);
        chk("fwd_st", st_value_out, 32'hAB);

        run_mul(32'd7, 32'd6, 2'd0, 2'd0, 32'd0, 32'd0);
        idle_nop();
        run_mul(32'hFFFF_FFFF, 32'd2, 2'd0, 2'd0, 32'd0, 32'd0);
        idle_nop();
        run_mul(32'd99, 32'd4, 2'd1, 2'd0, 32'd3, 32'd0);
        idle_nop();
        run_mul(32'd2, 32'd3, 2'd0, 2'd0, 32'd0, 32'd0);
        run_mul(32'd5, 32'd5, 2'd0, 2'd0, 32'd0, 32'd0);
        idle_nop();

        next_cycle();
        EXE_CMD = 4'b1100; val1 = 32'd9; val2 = 32'd9; sel_src1 = 2'd0; sel_src2 = 2'd0;
        for (int c = 1; c <= 9; c++) next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_stall", {31'd0, stall}, 32'd0);
        chk("abort_busy", {31'd0, mul_busy}, 32'd0);
        next_cycle();
        rst = 1'b0;
        EXE_CMD = 4'b1111;
        @(negedge clk);
        chk("post_abort_busy", {31'd0, mul_busy}, 32'd0);
        chk("post_abort_stall", {31'd0, stall}, 32'd0);
        run_mul(32'd11, 32'd13, 2'd0, 2'd0, 32'd0, 32'd0);
        idle_nop();

        for (int i = 0; i < 200; i++) rand_alu();
        for (int i = 0; i < 5; i++) begin
            run_mul(rand_word(), rand_word(), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    $urandom, $urandom);
            if ($urandom_range(0, 1) == 1) idle_nop();
        end
        idle_nop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
